l2_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single L2 cache request port among four L1 cache controllers, one per processor. Each L1 controller raises a read-fill or write-back request. The arbiter picks one, stamps the owner's processor ID into address bits [31:30], and drives the L2 handshake. It returns the L2 line to the winner, or flags a timeout error if L2 never answers.

---
 rtl/l2_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
//
// Round-robin arbiter and sequencer sharing one L2 request port among four
// L1 cache controllers. The winner's request is registered, its processor ID
// is stamped into address bits [31:30], and the L2 handshake is driven until
// l2_ready arrives or the timeout expires. A one-cycle completion pulse, with
// the fill line or a timeout error, is then returned to the winner.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_write     per-requester request and write-back flag
//   req_addr/req_wdata      packed per-requester address and write-back line
//   grant                   one-hot owner, high while the transaction is active
//   resp_valid/resp_err     completion pulse to the owner, error = timeout
//   resp_rdata              fill line returned with resp_valid
//   l2_req/l2_write         L2 request and write-back flag
//   l2_addr/l2_wdata        L2 address (owner ID in top two bits) and line
//   l2_ready/l2_rdata       L2 completion strobe and fill data

module l2_port_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int TIMEOUT       = 64
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LINE_WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                 grant,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic                               resp_err,
  output logic [LINE_WIDTH-1:0]              resp_rdata,
  output logic                               l2_req,
  output logic                               l2_write,
  output logic [ADDRESS_WIDTH-1:0]           l2_addr,
  output logic [LINE_WIDTH-1:0]              l2_wdata,
  input  logic                               l2_ready,
  input  logic [LINE_WIDTH-1:0]              l2_rdata
);

  localparam int IDX_W = 2;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]           owner_q, owner_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [NUM_REQ-1:0]         grant_q, grant_d;
  logic [NUM_REQ-1:0]         resp_valid_q, resp_valid_d;
  logic                       resp_err_q, resp_err_d;
  logic [LINE_WIDTH-1:0]      resp_rdata_q, resp_rdata_d;
  logic                       l2_req_q, l2_req_d;
  logic                       l2_write_q, l2_write_d;
  logic [ADDRESS_WIDTH-1:0]   l2_addr_q, l2_addr_d;
  logic [LINE_WIDTH-1:0]      l2_wdata_q, l2_wdata_d;

  logic                       win_found;
  logic [IDX_W-1:0]           win_idx;
  logic [IDX_W-1:0]           cand;
  logic [ADDRESS_WIDTH-1:0]   win_addr;

  // Round-robin search: first requester at or above rr_ptr, wrapping. The
  // 2-bit candidate index wraps naturally.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Winner's address with its processor ID overwriting the top two bits.
  always_comb begin
    win_addr = req_addr[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    win_addr[ADDRESS_WIDTH-1 -: IDX_W] = win_idx;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    tmo_d        = tmo_q;
    grant_d      = grant_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    l2_req_d     = l2_req_q;
    l2_write_d   = l2_write_q;
    l2_addr_d    = l2_addr_q;
    l2_wdata_d   = l2_wdata_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = BUSY;
          owner_d    = win_idx;
          tmo_d      = '0;
          grant_d    = NUM_REQ'(1) << win_idx;
          l2_req_d   = 1'b1;
          l2_write_d = req_write[win_idx];
          l2_addr_d  = win_addr;
          l2_wdata_d = req_wdata[int'(win_idx)*LINE_WIDTH +: LINE_WIDTH];
        end
      end

      BUSY: begin
        // l2_ready is tested first so a reply on the last allowed cycle
        // still completes without an error.
        if (l2_ready) begin
          state_d      = RESP;
          l2_req_d     = 1'b0;
          resp_valid_d = grant_q;
          resp_err_d   = 1'b0;
          resp_rdata_d = l2_rdata;
          tmo_d        = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d      = RESP;
          l2_req_d     = 1'b0;
          resp_valid_d = grant_q;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          tmo_d        = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RESP: begin
        state_d      = IDLE;
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        grant_d      = '0;
        rr_ptr_d     = owner_q + 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      tmo_q        <= '0;
      grant_q      <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      l2_req_q     <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_addr_q    <= '0;
      l2_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      tmo_q        <= tmo_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      l2_req_q     <= l2_req_d;
      l2_write_q   <= l2_write_d;
      l2_addr_q    <= l2_addr_d;
      l2_wdata_q   <= l2_wdata_d;
    end
  end

  assign grant      = grant_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign l2_req     = l2_req_q;
  assign l2_write   = l2_write_q;
  assign l2_addr    = l2_addr_q;
  assign l2_wdata   = l2_wdata_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter
//
// Self-checking bench for l2_port_arbiter. Requesters and the L2 side are
// driven on the falling edge. A transaction-level reference model (pending
// requests, round-robin pointer, transaction phase) predicts the owner and
// the L2 request fields; each expected completion is queued and a separate
// monitor pops and compares it when resp_valid appears.

module tb_l2_port_arbiter;

  localparam int NR      = 4;
  localparam int AW      = 32;
  localparam int LW      = 128;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_wdata;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    resp_valid;
  logic             resp_err;
  logic [LW-1:0]    resp_rdata;
  logic             l2_req;
  logic             l2_write;
  logic [AW-1:0]    l2_addr;
  logic [LW-1:0]    l2_wdata;
  logic             l2_ready;
  logic [LW-1:0]    l2_rdata;

  always #5 clk = ~clk;

  l2_port_arbiter #(
    .NUM_REQ(NR), .ADDRESS_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .l2_req(l2_req), .l2_write(l2_write), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_ready(l2_ready), .l2_rdata(l2_rdata)
  );

  typedef struct {
    int            owner;
    logic          err;
    logic [LW-1:0] rdata;
    int            at_cyc;
  } resp_t;

  typedef enum {M_IDLE, M_BUSY, M_RESP} mphase_e;

  resp_t   exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;

  // Reference model state
  mphase_e       phase;
  int            owner, k, delay, ptr;
  logic          ready_drv;
  logic [AW-1:0] exp_addr;
  logic          exp_write;
  logic [LW-1:0] exp_wdata;
  logic [NR-1:0] waiting;

  // Stimulus knobs
  logic [NR-1:0] raise_mask;
  int            pct_raise;
  int            perturb_pct;
  int            fixed_delay;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [LW-1:0] act,
                             input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int pick_delay();
    int r;
    if (fixed_delay >= 0) return fixed_delay;
    r = int'($urandom_range(99));
    if (r < 60) return int'($urandom_range(3));
    if (r < 85) return int'($urandom_range(TIMEOUT-2, 4));
    if (r < 92) return TIMEOUT - 1;
    return TIMEOUT + 10;
  endfunction

  task automatic raiseReq(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [LW-1:0] d);
    req_valid[i]            = 1'b1;
    req_write[i]            = wr;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*LW +: LW]   = d;
    waiting[i]              = 1'b1;
  endtask

  // One clock cycle: advance the model, check the L2 side, drive L2 and requesters.
  task automatic applyStimulus();
    logic [NR-1:0] sampled;
    logic [NR-1:0] released;
    logic [NR-1:0] eg;
    resp_t         e;
    @(negedge clk);
    sampled  = req_valid;
    released = '0;
    for (int i = 0; i < NR; i++) begin
      if (resp_valid[i] && waiting[i]) begin
        req_valid[i] = 1'b0;
        waiting[i]   = 1'b0;
        released[i]  = 1'b1;
      end
    end

    case (phase)
      M_IDLE: begin
        if (sampled != '0) begin
          owner = -1;
          for (int j = 0; j < NR; j++)
            if (owner < 0 && sampled[(ptr + j) % NR]) owner = (ptr + j) % NR;
          exp_write = req_write[owner];
          exp_addr  = req_addr[owner*AW +: AW];
          exp_addr[AW-1 -: 2] = 2'(owner);
          exp_wdata = req_wdata[owner*LW +: LW];
          phase = M_BUSY;
          k     = 0;
          delay = pick_delay();
        end
      end
      M_BUSY: begin
        if (ready_drv || k == TIMEOUT - 1) phase = M_RESP;
        else k++;
      end
      default: begin
        phase = M_IDLE;
        ptr   = (owner + 1) % NR;
      end
    endcase

    eg = (phase == M_IDLE) ? '0 : (4'b0001 << owner);
    checkOutput("l2_req", LW'(l2_req), LW'(phase == M_BUSY));
    checkOutput("grant", LW'(grant), LW'(eg));
    if (phase == M_BUSY) begin
      checkOutput("l2_addr", LW'(l2_addr), LW'(exp_addr));
      checkOutput("l2_write", LW'(l2_write), LW'(exp_write));
      checkOutput("l2_wdata", l2_wdata, exp_wdata);
    end

    l2_rdata  = rand_line();
    ready_drv = (phase == M_BUSY) && (k == delay);
    l2_ready  = ready_drv;
    if (ready_drv) begin
      e.owner = owner; e.err = 1'b0; e.rdata = l2_rdata; e.at_cyc = cyc + 1;
      exp_q.push_back(e);
    end else if (phase == M_BUSY && k == TIMEOUT - 1) begin
      e.owner = owner; e.err = 1'b1; e.rdata = '0; e.at_cyc = cyc + 1;
      exp_q.push_back(e);
    end

    for (int i = 0; i < NR; i++) begin
      if (!waiting[i] && !released[i] && raise_mask[i] &&
          int'($urandom_range(99)) < pct_raise) begin
        raiseReq(i, 1'($urandom_range(1)), $urandom, rand_line());
      end else if (waiting[i] && phase == M_BUSY && i == owner &&
                   int'($urandom_range(99)) < perturb_pct) begin
        req_write[i]          = ~req_write[i];
        req_addr[i*AW +: AW]  = $urandom;
        req_wdata[i*LW +: LW] = rand_line();
        if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) applyStimulus();
  endtask

  // Monitor: every completion pulse must match the head of the scoreboard.
  initial begin
    resp_t m;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (exp_q.size() > 0 && exp_q[0].at_cyc < cyc) begin
          m = exp_q.pop_front();
          checkOutput("resp_missing", LW'(resp_valid), LW'(4'b0001 << m.owner));
        end
        if (resp_valid != '0) begin
          if (exp_q.size() == 0) begin
            checkOutput("resp_unexpected", LW'(resp_valid), '0);
          end else begin
            m = exp_q.pop_front();
            checkOutput("resp_valid", LW'(resp_valid), LW'(4'b0001 << m.owner));
            checkOutput("resp_err", LW'(resp_err), LW'(m.err));
            checkOutput("resp_rdata", resp_rdata, m.rdata);
            checkOutput("resp_cycle", LW'(cyc), LW'(m.at_cyc));
          end
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_grant"}, LW'(grant), '0);
    checkOutput({tag, "_resp_valid"}, LW'(resp_valid), '0);
    checkOutput({tag, "_resp_err"}, LW'(resp_err), '0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, '0);
    checkOutput({tag, "_l2_req"}, LW'(l2_req), '0);
    checkOutput({tag, "_l2_write"}, LW'(l2_write), '0);
    checkOutput({tag, "_l2_addr"}, LW'(l2_addr), '0);
    checkOutput({tag, "_l2_wdata"}, l2_wdata, '0);
  endtask

  task automatic modelReset();
    phase     = M_IDLE;
    ptr       = 0;
    owner     = 0;
    k         = 0;
    delay     = 0;
    ready_drv = 1'b0;
    exp_q.delete();
    req_valid = '0;
    waiting   = '0;
    l2_ready  = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    l2_rdata    = '0;
    raise_mask  = '0;
    pct_raise   = 0;
    perturb_pct = 0;
    fixed_delay = -1;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset_n = 1'b1;

    $display("[TB] read from requester 2, L2 replies 3 cycles after l2_req");
    fixed_delay = 3;
    raiseReq(2, 1'b0, 32'h0000_0040, rand_line());
    run(10);

    $display("[TB] all four requesters at once, immediate L2 reply");
    fixed_delay = 0;
    for (int i = 0; i < NR; i++) raiseReq(i, 1'($urandom_range(1)), $urandom, rand_line());
    run(16);

    $display("[TB] requester 0 re-requests while 3 is pending");
    raiseReq(0, 1'b0, $urandom, rand_line());
    raiseReq(3, 1'b1, $urandom, rand_line());
    raise_mask = 4'b0001;
    pct_raise  = 100;
    run(10);
    raise_mask = '0;
    run(8);

    $display("[TB] L2 never answers, then answers on the last allowed cycle");
    fixed_delay = 1000;
    raiseReq(1, 1'b0, $urandom, rand_line());
    run(TIMEOUT + 6);
    fixed_delay = TIMEOUT - 1;
    raiseReq(0, 1'b0, $urandom, rand_line());
    run(TIMEOUT + 6);

    $display("[TB] write-back from requester 1 with inputs changing while busy");
    fixed_delay = 5;
    perturb_pct = 100;
    raiseReq(1, 1'b1, 32'hC000_1000, {16{8'hA5}});
    run(12);
    perturb_pct = 0;

    $display("[TB] reset while busy");
    fixed_delay = 1000;
    raiseReq(3, 1'b0, $urandom, rand_line());
    run(5);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_l2_req", LW'(l2_req), '0);
    checkOutput("abort_grant", LW'(grant), '0);
    checkOutput("abort_resp_valid", LW'(resp_valid), '0);
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run(4);
    fixed_delay = 0;
    raiseReq(1, 1'b0, $urandom, rand_line());
    raiseReq(3, 1'b0, $urandom, rand_line());
    run(12);

    $display("[TB] random traffic");
    fixed_delay = -1;
    raise_mask  = 4'b1111;
    pct_raise   = 30;
    perturb_pct = 20;
    run(3000);
    raise_mask  = '0;
    perturb_pct = 0;
    run(400);

    checkOutput("scoreboard_empty", LW'(exp_q.size()), '0);
    checkOutput("all_served", LW'(waiting), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
